// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcode/funct encodings, the fetch
// state type and the default boot address.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request, a hold register
// with valid/ready towards decode, and branch redirect with wrong-path kill.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_opcode,
  output logic [5:0]        if_funct,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [31:0]       fetch_count
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [ADDR_W-1:0] br_pc;

  assign br_pc       = {br_target[ADDR_W-1:2], 2'b00};
  assign imem_addr   = pc;
  assign if_opcode   = if_instr[31:26];
  assign if_funct    = if_instr[5:0];
  assign if_pc_plus4 = if_pc + ADDR_W'(4);

  // imem_req and if_valid are set on the transition into S_REQ / S_HOLD so
  // both come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= RESET_PC;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_taken) pc <= br_pc;
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          // The request already on the bus used the old pc; it must be killed.
          if (br_taken) begin
            pc   <= br_pc;
            kill <= 1'b1;
          end
          state    <= S_WAIT;
          imem_req <= 1'b0;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill || br_taken) begin
              if (br_taken) pc <= br_pc;
              kill     <= 1'b0;
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (br_taken) begin
            pc   <= br_pc;
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (br_taken) begin
            pc       <= br_pc;
            if_valid <= 1'b0;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else if (if_ready) begin
            pc          <= pc + ADDR_W'(4);
            fetch_count <= fetch_count + 32'd1;
            if_valid    <= 1'b0;
            state       <= S_REQ;
            imem_req    <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset corner cases,
// randomized traffic against a transaction-level model, and pc wrap.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        imem_req, imem_rvalid, br_taken, if_valid, if_ready;
  logic [31:0] imem_addr, imem_rdata, br_target, if_instr, if_pc, if_pc_plus4, fetch_count;
  logic [5:0]  if_opcode, if_funct;

  logic        w_req, w_rvalid, w_br, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_target, w_instr, w_pc, w_pc_plus4, w_count;
  logic [5:0]  w_opcode, w_funct;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_opcode(if_opcode), .if_funct(if_funct),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .br_taken(w_br), .br_target(w_target),
    .if_valid(w_valid), .if_ready(w_ready), .if_instr(w_instr),
    .if_opcode(w_opcode), .if_funct(w_funct),
    .if_pc(w_pc), .if_pc_plus4(w_pc_plus4), .fetch_count(w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0109_5020;
  endfunction

  task automatic clear_inputs();
    imem_rvalid = 0; imem_rdata = 0; br_taken = 0; br_target = 0; if_ready = 0;
    w_rvalid = 0; w_rdata = 0; w_br = 0; w_target = 0; w_ready = 0;
  endtask

  // Leaves the bench at the first falling edge after release (FSM in S_IDLE).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_count;
  } vec_t;

  vec_t tbl[21];

  // Random-phase model state
  logic [31:0] m_pc, m_count, last_addr, prev_instr, prev_pc, exp_w;
  int unsigned m_epoch, last_epoch;
  bit          outst, prev_stall, prev_valid;
  int          t_left, idle;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rv  rdata          rdy br  target        req addr          vld instr          pc            cnt
    tbl[0]  = '{0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        0};
    tbl[1]  = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h3000,      0, 32'h0,         32'h0,        0};
    tbl[2]  = '{1, 32'h8C08_0004, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        0};
    tbl[3]  = '{0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h8C08_0004, 32'h3000,     0};
    tbl[4]  = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h3004,      0, 32'h0,         32'h0,        1};
    tbl[5]  = '{1, 32'h0109_5020, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        1};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         1, 32'h0109_5020, 32'h3004,     1};
    tbl[11] = '{0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h0109_5020, 32'h3004,     1};
    tbl[12] = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h3008,      0, 32'h0,         32'h0,        2};
    tbl[13] = '{0, 32'h0,         0, 1, 32'h3043,      0, 32'h0,         0, 32'h0,         32'h0,        2};
    tbl[14] = '{0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        2};
    tbl[15] = '{0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        2};
    tbl[16] = '{1, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        2};
    tbl[17] = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h3040,      0, 32'h0,         32'h0,        2};
    tbl[18] = '{1, 32'h1000_0004, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,        2};
    tbl[19] = '{0, 32'h0,         1, 1, 32'h3040,      0, 32'h0,         1, 32'h1000_0004, 32'h3040,     2};
    tbl[20] = '{0, 32'h0,         0, 0, 32'h0,         1, 32'h3040,      0, 32'h0,         32'h0,        2};

    clear_inputs();
    do_reset();
    check("reset_if_instr", if_instr, 32'h0);
    check("reset_if_pc", if_pc, 32'h3000);

    for (int i = 0; i < 21; i++) begin
      imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
      if_ready = tbl[i].ready; br_taken = tbl[i].br; br_target = tbl[i].target;
      check($sformatf("vec%0d_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_valid", i), if_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        exp_w = tbl[i].e_instr;
        check($sformatf("vec%0d_instr", i), if_instr, exp_w);
        check($sformatf("vec%0d_opcode", i), if_opcode, exp_w[31:26]);
        check($sformatf("vec%0d_funct", i), if_funct, exp_w[5:0]);
        check($sformatf("vec%0d_pc", i), if_pc, tbl[i].e_pc);
        check($sformatf("vec%0d_pc_plus4", i), if_pc_plus4, tbl[i].e_pc + 32'd4);
      end
      check($sformatf("vec%0d_count", i), fetch_count, tbl[i].e_count);
      @(negedge clk);
    end

    // Reset asserted while a request is outstanding, then a stale response.
    clear_inputs();
    rst_n = 0;
    #1;
    check("midrst_req", imem_req, 0);
    check("midrst_valid", if_valid, 0);
    check("midrst_count", fetch_count, 0);
    check("midrst_pc", if_pc, 32'h3000);
    check("midrst_instr", if_instr, 32'h0);
    @(negedge clk);
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    check("stale0_req", imem_req, 0);
    check("stale0_valid", if_valid, 0);
    @(negedge clk);
    check("stale1_req", imem_req, 1);
    check("stale1_addr", imem_addr, 32'h3000);
    check("stale1_valid", if_valid, 0);
    imem_rvalid = 0;
    repeat (2) begin
      @(negedge clk);
      check("stale_valid", if_valid, 0);
    end

    // Randomized traffic: variable memory latency, backpressure, redirects.
    do_reset();
    m_pc = 32'h3000; m_count = 0; m_epoch = 0; last_epoch = 0; last_addr = 0;
    outst = 0; t_left = 0; prev_stall = 0; prev_valid = 0; idle = 0;
    prev_instr = 0; prev_pc = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_rvalid = 0; imem_rdata = 0;
      if (outst) begin
        t_left--;
        if (t_left == 0) begin
          imem_rvalid = 1; imem_rdata = mem_word(last_addr); outst = 0;
        end
      end
      if (imem_req) begin
        check("rnd_one_outstanding", outst, 0);
        check("rnd_req_addr", imem_addr, m_pc);
        outst = 1; t_left = $urandom_range(1, 3);
        last_addr = imem_addr; last_epoch = m_epoch; idle = 0;
      end
      if (prev_stall) begin
        check("rnd_hold_valid", if_valid, 1);
        check("rnd_hold_instr", if_instr, prev_instr);
        check("rnd_hold_pc", if_pc, prev_pc);
      end
      if (if_valid && !prev_valid) begin
        check("rnd_wrong_path", last_epoch, m_epoch);
        check("rnd_instr", if_instr, mem_word(last_addr));
        check("rnd_if_pc", if_pc, last_addr);
      end
      check("rnd_count", fetch_count, m_count);

      if_ready = ($urandom % 4) != 0;
      br_taken = ($urandom % 12) == 0;
      br_target = $urandom;
      if (if_valid && if_ready && !br_taken) begin
        exp_w = mem_word(m_pc);
        check("rnd_deliver_pc", if_pc, m_pc);
        check("rnd_opcode", if_opcode, exp_w[31:26]);
        check("rnd_funct", if_funct, exp_w[5:0]);
        check("rnd_pc_plus4", if_pc_plus4, m_pc + 32'd4);
        m_count++; m_pc = m_pc + 32'd4; idle = 0;
      end
      if (br_taken) begin
        m_pc = {br_target[31:2], 2'b00};
        m_epoch++;
      end
      prev_stall = if_valid && !if_ready && !br_taken;
      prev_instr = if_instr; prev_pc = if_pc; prev_valid = if_valid;
      idle++;
      check("rnd_liveness", idle < 40, 1);
      @(negedge clk);
    end
    check("rnd_progress", m_count > 32'd100, 1);

    // PC wrap-around on the high-reset-address instance.
    do_reset();
    check("wrap_req0", w_req, 0);
    @(negedge clk);
    check("wrap_req1", w_req, 1);
    check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    w_rvalid = 1; w_rdata = 32'h3C01_1234;
    @(negedge clk);
    w_rvalid = 0; w_ready = 1;
    check("wrap_valid", w_valid, 1);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", w_pc_plus4, 32'h0);
    check("wrap_opcode", w_opcode, 6'b001111);
    @(negedge clk);
    w_ready = 0;
    check("wrap_req_next", w_req, 1);
    check("wrap_addr_next", w_addr, 32'h0);
    check("wrap_count", w_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
